// File: rtl/latency_memory_if.sv
// Request/response bus for latency_memory.
// master: drives the request channel and the response ready (fetch/LSU side or bench).
// slave : the memory; drives req_ready and the response channel.
//   req_valid/req_ready  request handshake
//   req_addr             byte address
//   req_we               1 = write, 0 = read
//   req_wstrb            byte enables for writes
//   req_wdata            write data
//   rsp_valid/rsp_ready  response handshake
//   rsp_rdata            read data (0 for writes and errors)
//   rsp_err              out-of-range or misaligned access
interface latency_memory_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_we;
  logic [DATA_W/8-1:0]   req_wstrb;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_wstrb, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_wstrb, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/latency_memory.sv
// Word-organised RAM at BASE_ADDR with configurable access latency.
// One request outstanding at a time. The response appears LATENCY cycles after the
// cycle in which the request handshake is presented, and is held until rsp_ready.
// Byte-strobe writes; misaligned or out-of-range accesses return rsp_err with rdata 0.
// The array `memory` has no reset so that hierarchical preloads made during reset survive.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous reset, active-high
//   bus    latency_memory_if slave modport (request and response channels)
module latency_memory #(
  parameter int unsigned        ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 32'h8000_0000,
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        DEPTH     = 1024,
  parameter int unsigned        LATENCY   = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  latency_memory_if.slave    bus
);

  localparam int unsigned ByteW = DATA_W / 8;
  localparam int unsigned OffW  = $clog2(ByteW);
  localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW  = 4;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  logic [DATA_W-1:0] memory [DEPTH];

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  // Latched request, already decoded.
  logic [IdxW-1:0]   idx_q;
  logic              err_q;
  logic              we_q;
  logic [ByteW-1:0]  wstrb_q;
  logic [DATA_W-1:0] wdata_q;

  // Address decode of the live request. The subtraction wraps, so addresses below
  // BASE_ADDR become huge offsets and fall out of range.
  logic [ADDR_W-1:0] off;
  logic [ADDR_W-1:0] word;
  logic              dec_err;
  logic [IdxW-1:0]   dec_idx;

  assign off     = bus.req_addr - BASE_ADDR;
  assign word    = off >> OffW;
  assign dec_err = ((off & ADDR_W'(ByteW - 1)) != '0) || (word >= ADDR_W'(DEPTH));
  assign dec_idx = word[IdxW-1:0];

  logic accept;
  assign bus.req_ready = (state_q == StIdle) && !rst_i;
  assign accept        = bus.req_valid && bus.req_ready;

  // Commit happens on the edge that enters StResp. With LATENCY==1 that is the accept
  // edge itself, so the live request is used instead of the latched copy.
  logic              commit;
  logic [IdxW-1:0]   c_idx;
  logic              c_err;
  logic              c_we;
  logic [ByteW-1:0]  c_wstrb;
  logic [DATA_W-1:0] c_wdata;
  logic [DATA_W-1:0] c_rdata;

  always_comb begin
    commit  = 1'b0;
    c_idx   = idx_q;
    c_err   = err_q;
    c_we    = we_q;
    c_wstrb = wstrb_q;
    c_wdata = wdata_q;
    if (state_q == StIdle) begin
      c_idx   = dec_idx;
      c_err   = dec_err;
      c_we    = bus.req_we;
      c_wstrb = bus.req_wstrb;
      c_wdata = bus.req_wdata;
      commit  = accept && (LATENCY == 1);
    end else if (state_q == StWait) begin
      commit  = !rst_i && (cnt_q == CntW'(1));
    end
  end

  assign c_rdata = (c_we || c_err) ? '0 : memory[c_idx];

  always_ff @(posedge clk_i) begin
    if (commit && c_we && !c_err) begin
      for (int b = 0; b < int'(ByteW); b++) begin
        if (c_wstrb[b]) begin
          memory[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            idx_q   <= dec_idx;
            err_q   <= dec_err;
            we_q    <= bus.req_we;
            wstrb_q <= bus.req_wstrb;
            wdata_q <= bus.req_wdata;
            if (commit) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= c_rdata;
              rsp_err_q   <= c_err;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntW'(LATENCY - 1);
            end
          end
        end
        StWait: begin
          if (commit) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= c_rdata;
            rsp_err_q   <= c_err;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_latency_memory.sv
module tb_latency_memory;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  latency_memory_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();
  latency_memory_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  latency_memory #(.LATENCY(3)) u_dut3 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus3)
  );

  latency_memory #(.LATENCY(1)) u_dut1 (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the LATENCY=3 instance with rsp_ready held high.
  // lat counts edges from the accept edge (inclusive) until rsp_valid is seen.
  task automatic txn3(input logic we, input logic [31:0] addr, input logic [3:0] wstrb,
                      input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                      output logic err);
    int guard;
    @(negedge clk);
    bus3.req_valid = 1'b1;
    bus3.req_we    = we;
    bus3.req_addr  = addr;
    bus3.req_wstrb = wstrb;
    bus3.req_wdata = wdata;
    guard = 0;
    while (!bus3.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus3.req_valid = 1'b0;
    lat = 1;
    while (!bus3.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rdata = bus3.rsp_rdata;
    err   = bus3.rsp_err;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        er;
    logic [31:0] bad_addr [3];
    logic [31:0] exp1 [4];

    bad_addr[0] = 32'h7FFF_FFFC;
    bad_addr[1] = 32'h8000_1000;
    bad_addr[2] = 32'h8000_0002;
    exp1[0] = 32'h1111_1111;
    exp1[1] = 32'h2222_2222;
    exp1[2] = 32'h3333_3333;
    exp1[3] = 32'h4444_4444;

    vectors     = 0;
    miscompares = 0;
    clk = 1'b0;
    rst = 1'b1;
    bus3.req_valid = 1'b0; bus3.req_addr = '0; bus3.req_we = 1'b0;
    bus3.req_wstrb = '0;   bus3.req_wdata = '0; bus3.rsp_ready = 1'b1;
    bus1.req_valid = 1'b0; bus1.req_addr = '0; bus1.req_we = 1'b0;
    bus1.req_wstrb = '0;   bus1.req_wdata = '0; bus1.rsp_ready = 1'b1;

    // Preload while reset is asserted.
    #2;
    u_dut3.memory[0]     = 32'h0050_0093;
    u_dut3.memory[10'h101] = 32'h5555_5555;
    u_dut3.memory[10'h3FF] = 32'hA5A5_0FF0;
    for (int i = 0; i < 4; i++) u_dut1.memory[i] = exp1[i];

    repeat (3) @(posedge clk);
    #1;
    check("reset_rsp_valid", 32'(bus3.rsp_valid), 32'd0);
    check("reset_rsp_rdata", bus3.rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(bus3.rsp_err), 32'd0);
    check("reset_req_ready_in_rst", 32'(bus3.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_req_ready_after", 32'(bus3.req_ready), 32'd1);

    // T1: preloaded read, latency 3
    txn3(1'b0, 32'h8000_0000, 4'h0, 32'h0, lat, rd, er);
    check("t1_latency", 32'(lat), 32'd3);
    check("t1_rdata", rd, 32'h0050_0093);
    check("t1_err", 32'(er), 32'd0);

    // T2: strobed write then read back
    txn3(1'b1, 32'h8000_0404, 4'b0011, 32'h1234_5678, lat, rd, er);
    check("t2_wr_latency", 32'(lat), 32'd3);
    check("t2_wr_rdata", rd, 32'd0);
    check("t2_wr_err", 32'(er), 32'd0);
    txn3(1'b0, 32'h8000_0404, 4'h0, 32'h0, lat, rd, er);
    check("t2_rd_rdata", rd, 32'h5555_5678);

    // T3: backpressure with a pending second request
    @(negedge clk);
    bus3.rsp_ready = 1'b0;
    bus3.req_valid = 1'b1;
    bus3.req_we    = 1'b0;
    bus3.req_addr  = 32'h8000_0000;
    @(posedge clk);
    #1;
    bus3.req_addr = 32'h8000_0404;
    lat = 1;
    while (!bus3.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("t3_latency", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_hold_valid_%0d", i), 32'(bus3.rsp_valid), 32'd1);
      check($sformatf("t3_hold_rdata_%0d", i), bus3.rsp_rdata, 32'h0050_0093);
      check($sformatf("t3_hold_err_%0d", i), 32'(bus3.rsp_err), 32'd0);
      check($sformatf("t3_hold_ready_%0d", i), 32'(bus3.req_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    bus3.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t3_after_hs_valid", 32'(bus3.rsp_valid), 32'd0);
    check("t3_after_hs_ready", 32'(bus3.req_ready), 32'd1);
    @(posedge clk);
    #1;
    check("t3_second_accepted", 32'(bus3.req_ready), 32'd0);
    bus3.req_valid = 1'b0;
    lat = 1;
    while (!bus3.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("t3_second_latency", 32'(lat), 32'd3);
    check("t3_second_rdata", bus3.rsp_rdata, 32'h5555_5678);
    @(posedge clk);
    #1;

    // T4: error accesses, reads and writes
    for (int i = 0; i < 3; i++) begin
      txn3(1'b0, bad_addr[i], 4'h0, 32'h0, lat, rd, er);
      check($sformatf("t4_rd_err_%0d", i), 32'(er), 32'd1);
      check($sformatf("t4_rd_rdata_%0d", i), rd, 32'd0);
      txn3(1'b1, bad_addr[i], 4'hF, 32'hFFFF_FFFF, lat, rd, er);
      check($sformatf("t4_wr_err_%0d", i), 32'(er), 32'd1);
    end
    txn3(1'b0, 32'h8000_0000, 4'h0, 32'h0, lat, rd, er);
    check("t4_mem0_intact", rd, 32'h0050_0093);
    txn3(1'b0, 32'h8000_0FFC, 4'h0, 32'h0, lat, rd, er);
    check("t4_mem3ff_intact", rd, 32'hA5A5_0FF0);
    check("t4_mem3ff_err", 32'(er), 32'd0);

    // T5: reset while the write is waiting
    @(negedge clk);
    bus3.req_valid = 1'b1;
    bus3.req_we    = 1'b1;
    bus3.req_addr  = 32'h8000_0000;
    bus3.req_wstrb = 4'hF;
    bus3.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus3.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t5_rst_valid", 32'(bus3.rsp_valid), 32'd0);
    check("t5_rst_ready", 32'(bus3.req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("t5_release_ready", 32'(bus3.req_ready), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_late_rsp", 32'(bus3.rsp_valid), 32'd0);
    txn3(1'b0, 32'h8000_0000, 4'h0, 32'h0, lat, rd, er);
    check("t5_mem0_unchanged", rd, 32'h0050_0093);

    // T6: LATENCY=1 throughput with req_valid held high
    @(negedge clk);
    bus1.req_valid = 1'b1;
    bus1.req_we    = 1'b0;
    bus1.req_addr  = 32'h8000_0000;
    for (int k = 0; k <= 8; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t6_valid_e%0d", k), 32'(bus1.rsp_valid),
            32'((k % 2 == 0) && (k <= 6)));
      check($sformatf("t6_ready_e%0d", k), 32'(bus1.req_ready),
            32'((k % 2 == 1) || (k >= 7)));
      if ((k % 2 == 0) && (k <= 6)) begin
        check($sformatf("t6_rdata_e%0d", k), bus1.rsp_rdata, exp1[k/2]);
        if (k == 6) bus1.req_valid = 1'b0;
        else bus1.req_addr = 32'h8000_0000 + 32'(4 * (k/2 + 1));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
